imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised successor of the decode-stage immediate generator.
- Accepts LANES raw instructions per beat with their ImmGenType selectors, and produces XLEN-bit sign- or zero-extended immediates.
- Adds shift-amount formats and an illegal-shamt flag.
- Decouples decode from rename/issue through a valid/ready handshake with a 2-entry skid buffer, and supports pipeline flush.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- LANES, 1, instructions processed per beat (1..4).
- SHAMT_W, $clog2(XLEN), width of the legal shift-amount field.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  buffer can accept a beat.
- in_instr  in  LANES*32  raw instructions; lane i occupies [32i+31:32i].
- in_type  in  LANES*$bits(ImmGenType)  per-lane format select.
- in_lane_en  in  LANES  per-lane valid mask.
- out_valid  out  1  head beat valid.
- out_ready  in  1  downstream accepts head.
- out_imm  out  LANES*XLEN  per-lane immediates.
- out_lane_en  out  LANES  registered copy of in_lane_en.
- out_err  out  LANES  per-lane illegal-shamt flag.

Behaviour:
- Reset (reset_n low, asynchronous): both buffer entries are invalid; out_valid=0, out_imm=0, out_lane_en=0, out_err=0; in_ready=1 on the first cycle after reset is released.
- Handshake:
  - A beat is accepted when in_valid && in_ready at a clock edge.
  - The head beat is consumed when out_valid && out_ready.
  - Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N, when the buffer was empty.
  - in_ready = (count < 2). It is registered-derived and does not depend combinationally on out_ready.
  - Accept and consume in the same cycle leave count unchanged, and beat order is preserved.
  - Outputs are held stable while out_valid && !out_ready.
- Buffer:
  - 2 entries holding decoded imm/lane_en/err.
  - Head/tail pointers are 1 bit and wrap modulo 2; count is 0..2.
  - The full state (count=2) blocks acceptance; the empty state drives out_valid=0.
- Flush:
  - On a clock edge with flush=1, count is set to 0 and the input beat of that cycle is discarded even if in_valid && in_ready.
  - out_valid=0 in the following cycle.
  - Flush has priority over every other event.
- Decode is applied per lane, combinationally before the buffer write. Disabled lanes (in_lane_en[i]=0) write imm=0 and err=0.
  - NoGen: 0.
  - Gen_1 (I): sext(instr[31:20]).
  - Gen_2 (U): sext({instr[31:12],12'b0}) from bit 31.
  - Gen_3 (B): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Gen_4 (S): sext({instr[31:25],instr[11:7]}).
  - Gen_5 (J): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Gen_CSR: zext(instr[19:15]).
  - Gen_SHAMT (new): zext(instr[25:20]). err=1 if XLEN=32 and instr[25]=1; imm is still produced.
  - Gen_SHAMTW (new): zext(instr[24:20]). err is always 0.
  - Any undefined encoding: imm=0, err=0.
- Width rules:
  - All extension targets XLEN.
  - With XLEN=32, Gen_2 yields {instr[31:12],12'b0} with no upper extension.

Decomposition:
- The pipes package gains the Gen_SHAMT and Gen_SHAMTW enumerators in ImmGenType.
- The pipes package also gains a typedef imm_beat_t {logic [LANES-1:0] en; u64 imm[LANES]; logic [LANES-1:0] err}, sized at the maximum LANES.
- The common package holds XLEN_MAX=64.
- One natural sub-module, imm_lane_dec: the purely combinational per-lane decoder (instr, type -> imm, err), instantiated LANES times in a generate loop.
- The skid buffer and handshake remain in imm_gen_pipe.

Test Plan:
- XLEN=64, LANES=1. Drive 0xFFF00093/Gen_1 (addi -1), then 0x12345037/Gen_2, then 0x800000B7/Gen_2, then 0xFE000EE3/Gen_3 (beq -4).
  Required: out_imm = 0xFFFFFFFFFFFFFFFF, 0x0000000012345000, 0xFFFFFFFF80000000, 0xFFFFFFFFFFFFFFFC, each one cycle after acceptance.
- Drive 0x03F09093 (slli 63) with Gen_SHAMT.
  Required: XLEN=64 gives imm=63, err=0; XLEN=32 gives imm=63, err=1; Gen_SHAMTW gives imm=31, err=0.
- Hold out_ready=0 and offer beats A, B, C back-to-back.
  Required: in_ready=0 after A and B are accepted; C is stalled; out_imm holds A. Raising out_ready yields A, B, C in order with no loss or duplication.
- Buffer holds 2 beats; assert flush together with in_valid=1.
  Required: next cycle out_valid=0, count=0, in_ready=1; the input beat of the flush cycle never appears.
- LANES=2, in_lane_en=2'b10, lane0=0xFFF00093/Gen_1, lane1=0x000012B7/Gen_2.
  Required: out_imm lane0=0, lane1=0x1000, out_lane_en=2'b10.
- Pull reset_n low mid-stall with 2 entries full.
  Required: out_valid drops asynchronously, before the next clk edge; all outputs read 0; after release, in_ready=1 and no stale beat emerges.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the pipelined immediate generator: format selector, beat record
// and the width limits the rest of the slice is sized against.
package imm_gen_pipe_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int LANES_MAX = 4;

    typedef logic [XLEN_MAX-1:0] u64;

    typedef enum logic [3:0] {
        NoGen      = 4'd0,
        Gen_1      = 4'd1,
        Gen_2      = 4'd2,
        Gen_3      = 4'd3,
        Gen_4      = 4'd4,
        Gen_5      = 4'd5,
        Gen_CSR    = 4'd6,
        Gen_SHAMT  = 4'd7,
        Gen_SHAMTW = 4'd8
    } ImmGenType;

    // One decoded beat at the widest configuration; narrower builds use the low lanes/bits.
    typedef struct packed {
        logic [LANES_MAX-1:0] en;
        u64   [LANES_MAX-1:0] imm;
        logic [LANES_MAX-1:0] err;
    } imm_beat_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-issue stream carrying raw instructions in and decoded immediates out.
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int LANES = 1
) ();

    localparam int TW = $bits(ImmGenType);

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*32-1:0]     in_instr;
    logic [LANES*TW-1:0]     in_type;
    logic [LANES-1:0]        in_lane_en;

    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*XLEN-1:0]   out_imm;
    logic [LANES-1:0]        out_lane_en;
    logic [LANES-1:0]        out_err;

    modport master (
        output in_valid, in_instr, in_type, in_lane_en, out_ready,
        input  in_ready, out_valid, out_imm, out_lane_en, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_lane_en, out_ready,
        output in_ready, out_valid, out_imm, out_lane_en, out_err
    );

endinterface

// File: rtl/imm_gen_pipe_lane_dec.sv
// Purely combinational single-lane immediate decoder: instruction + format -> XLEN immediate
// and illegal-shift-amount flag.
module imm_lane_dec
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [31:0]     instr,
    input  ImmGenType       imm_type,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    u64         imm_full;
    logic [5:0] shamt;
    logic       unused_opcode;

    assign shamt         = instr[25:20];
    // Opcode bits never contribute to an immediate.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm_full = '0;
        err      = 1'b0;
        case (imm_type)
            Gen_1:      imm_full = {{52{instr[31]}}, instr[31:20]};
            Gen_2:      imm_full = {{32{instr[31]}}, instr[31:12], 12'b0};
            Gen_3:      imm_full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                                    instr[11:8], 1'b0};
            Gen_4:      imm_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            Gen_5:      imm_full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                                    instr[30:21], 1'b0};
            Gen_CSR:    imm_full = {59'b0, instr[19:15]};
            Gen_SHAMT: begin
                // Any shift-amount bit at or above SHAMT_W is out of range for this XLEN.
                imm_full = {58'b0, shamt};
                err      = (shamt >> SHAMT_W) != 6'd0;
            end
            Gen_SHAMTW: imm_full = {59'b0, instr[24:20]};
            default:    imm_full = '0;
        endcase
    end

    // Sign extension was done to 64 bits, so truncation gives the correct XLEN=32 result.
    assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered multi-lane immediate generator with a 2-entry skid buffer and flush,
// decoupling decode from rename/issue.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int LANES   = 1,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam int TW = $bits(ImmGenType);

    logic [LANES*XLEN-1:0] dec_imm;
    logic [LANES-1:0]      dec_err;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [XLEN-1:0] lane_imm;
            logic            lane_err;

            imm_lane_dec #(
                .XLEN    (XLEN),
                .SHAMT_W (SHAMT_W)
            ) u_dec (
                .instr    (bus.in_instr[32*gi +: 32]),
                .imm_type (ImmGenType'(bus.in_type[TW*gi +: TW])),
                .imm      (lane_imm),
                .err      (lane_err)
            );

            // Disabled lanes carry zeros so downstream never sees stale decode.
            assign dec_imm[XLEN*gi +: XLEN] = bus.in_lane_en[gi] ? lane_imm : '0;
            assign dec_err[gi]              = bus.in_lane_en[gi] & lane_err;
        end
    endgenerate

    logic [LANES*XLEN-1:0] imm_buf_reg [2];
    logic [LANES-1:0]      en_buf_reg  [2];
    logic [LANES-1:0]      err_buf_reg [2];
    logic                  head_reg;
    logic                  tail_reg;
    logic [1:0]            count_reg;
    logic                  push;
    logic                  pop;

    // Ready comes only from the stored count, never from out_ready.
    assign bus.in_ready  = (count_reg != 2'd2);
    assign bus.out_valid = (count_reg != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                imm_buf_reg[i] <= '0;
                en_buf_reg[i]  <= '0;
                err_buf_reg[i] <= '0;
            end
        end else if (flush) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            if (push) begin
                imm_buf_reg[tail_reg] <= dec_imm;
                en_buf_reg[tail_reg]  <= bus.in_lane_en;
                err_buf_reg[tail_reg] <= dec_err;
                tail_reg              <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.out_imm     = bus.out_valid ? imm_buf_reg[head_reg] : '0;
    assign bus.out_lane_en = bus.out_valid ? en_buf_reg[head_reg]  : '0;
    assign bus.out_err     = bus.out_valid ? err_buf_reg[head_reg] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64/32 single-lane and XLEN=64 dual-lane instances.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    imm_gen_pipe_if #(.XLEN(64), .LANES(1)) bus64 ();
    imm_gen_pipe_if #(.XLEN(32), .LANES(1)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .LANES(2)) bus2  ();

    imm_gen_pipe #(.XLEN(64), .LANES(1)) dut64 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus64));
    imm_gen_pipe #(.XLEN(32), .LANES(1)) dut32 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .LANES(2)) dut2  (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        ImmGenType   t;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [31:0] instr, input ImmGenType t);
        bus64.in_valid = 1'b1; bus64.in_instr = instr; bus64.in_type = t; bus64.in_lane_en = 1'b1;
        bus32.in_valid = 1'b1; bus32.in_instr = instr; bus32.in_type = t; bus32.in_lane_en = 1'b1;
    endtask

    task automatic idle1();
        bus64.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus64.in_valid = 0; bus64.in_instr = '0; bus64.in_type = '0; bus64.in_lane_en = '0; bus64.out_ready = 1;
        bus32.in_valid = 0; bus32.in_instr = '0; bus32.in_type = '0; bus32.in_lane_en = '0; bus32.out_ready = 1;
        bus2.in_valid  = 0; bus2.in_instr  = '0; bus2.in_type  = '0; bus2.in_lane_en  = '0; bus2.out_ready  = 1;
        #2;
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid=%b expected 0", bus64.out_valid); end
        checks++; if (bus64.out_imm !== 64'h0) begin errors++; $display("FAIL reset out_imm=%h expected 0", bus64.out_imm); end
        checks++; if (bus64.out_lane_en !== 1'b0) begin errors++; $display("FAIL reset out_lane_en=%b expected 0", bus64.out_lane_en); end
        checks++; if (bus64.out_err !== 1'b0) begin errors++; $display("FAIL reset out_err=%b expected 0", bus64.out_err); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready=%b expected 1", bus64.in_ready); end
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL post-reset out_valid=%b expected 0", bus64.out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_decode();
        logic [63:0] exp;
        logic [31:0] exp32;
        vecs[0] = '{32'hFFF00093, Gen_1,   64'hFFFFFFFFFFFFFFFF};
        vecs[1] = '{32'h12345037, Gen_2,   64'h0000000012345000};
        vecs[2] = '{32'h800000B7, Gen_2,   64'hFFFFFFFF80000000};
        vecs[3] = '{32'hFE000EE3, Gen_3,   64'hFFFFFFFFFFFFFFFC};
        vecs[4] = '{32'h80000F80, Gen_4,   64'hFFFFFFFFFFFFF81F};
        vecs[5] = '{32'h0010006F, Gen_5,   64'h0000000000000800};
        vecs[6] = '{32'h000F8073, Gen_CSR, 64'h000000000000001F};
        vecs[7] = '{32'hFFFFFFFF, NoGen,   64'h0};
        vecs[8] = '{32'hFFFFFFFF, ImmGenType'(4'hF), 64'h0};
        for (int i = 0; i < 9; i++) begin
            drive1(vecs[i].instr, vecs[i].t);
            tick();
            exp   = vecs[i].exp;
            exp32 = exp[31:0];
            checks++; if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL decode[%0d] out_valid=%b expected 1", i, bus64.out_valid); end
            checks++; if (bus64.out_imm !== exp) begin errors++; $display("FAIL decode64[%0d] out_imm=%h expected %h", i, bus64.out_imm, exp); end
            checks++; if (bus32.out_imm !== exp32) begin errors++; $display("FAIL decode32[%0d] out_imm=%h expected %h", i, bus32.out_imm, exp32); end
            $display("decode[%0d] instr=%h type=%0d imm64=%h imm32=%h", i, vecs[i].instr, vecs[i].t, bus64.out_imm, bus32.out_imm);
        end
        idle1();
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL decode drain out_valid=%b expected 0", bus64.out_valid); end
    endtask

    task automatic test_shamt();
        logic [31:0] instr [3];
        ImmGenType   t     [3];
        logic [63:0] exp   [3];
        logic        err32 [3];
        instr = '{32'h03F09093, 32'h03F09093, 32'h01F09093};
        t     = '{Gen_SHAMT, Gen_SHAMTW, Gen_SHAMT};
        exp   = '{64'd63, 64'd31, 64'd31};
        err32 = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive1(instr[i], t[i]);
            tick();
            checks++; if (bus64.out_imm !== exp[i]) begin errors++; $display("FAIL shamt64[%0d] out_imm=%h expected %h", i, bus64.out_imm, exp[i]); end
            checks++; if (bus64.out_err !== 1'b0) begin errors++; $display("FAIL shamt64[%0d] out_err=%b expected 0", i, bus64.out_err); end
            checks++; if (bus32.out_imm !== exp[i][31:0]) begin errors++; $display("FAIL shamt32[%0d] out_imm=%h expected %h", i, bus32.out_imm, exp[i][31:0]); end
            checks++; if (bus32.out_err !== err32[i]) begin errors++; $display("FAIL shamt32[%0d] out_err=%b expected %b", i, bus32.out_err, err32[i]); end
            $display("shamt[%0d] type=%0d imm64=%0d err64=%b imm32=%0d err32=%b", i, t[i], bus64.out_imm, bus64.out_err, bus32.out_imm, bus32.out_err);
        end
        idle1();
        tick();
    endtask

    task automatic test_back_to_back();
        bus64.out_ready = 1'b0;
        drive1(32'h00100093, Gen_1);
        tick();
        checks++; if (bus64.out_imm !== 64'd1) begin errors++; $display("FAIL b2b A out_imm=%h expected 1", bus64.out_imm); end
        checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL b2b A in_ready=%b expected 1", bus64.in_ready); end
        drive1(32'h00200093, Gen_1);
        tick();
        checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL b2b full in_ready=%b expected 0", bus64.in_ready); end
        drive1(32'h00300093, Gen_1);
        tick();
        checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL b2b stall in_ready=%b expected 0", bus64.in_ready); end
        checks++; if (bus64.out_imm !== 64'd1) begin errors++; $display("FAIL b2b hold out_imm=%h expected 1", bus64.out_imm); end
        bus64.out_ready = 1'b1;
        tick();
        checks++; if (bus64.out_imm !== 64'd2) begin errors++; $display("FAIL b2b second out_imm=%h expected 2", bus64.out_imm); end
        tick();
        idle1();
        checks++; if (bus64.out_imm !== 64'd3) begin errors++; $display("FAIL b2b third out_imm=%h expected 3", bus64.out_imm); end
        checks++; if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL b2b third out_valid=%b expected 1", bus64.out_valid); end
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL b2b drained out_valid=%b expected 0", bus64.out_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        bus64.out_ready = 1'b0;
        drive1(32'h00100093, Gen_1);
        tick();
        drive1(32'h00200093, Gen_1);
        tick();
        drive1(32'h00300093, Gen_1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle1();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid=%b expected 0", bus64.out_valid); end
        checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready=%b expected 1", bus64.in_ready); end
        bus64.out_ready = 1'b1;
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL flush discard out_valid=%b expected 0", bus64.out_valid); end
        drive1(32'h00400093, Gen_1);
        tick();
        idle1();
        checks++; if (bus64.out_imm !== 64'd4) begin errors++; $display("FAIL flush resume out_imm=%h expected 4", bus64.out_imm); end
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL flush resume drain out_valid=%b expected 0", bus64.out_valid); end
        $display("test_flush done");
    endtask

    task automatic test_lanes();
        bus2.in_valid   = 1'b1;
        bus2.in_instr   = {32'h000012B7, 32'hFFF00093};
        bus2.in_type    = {Gen_2, Gen_1};
        bus2.in_lane_en = 2'b10;
        tick();
        checks++; if (bus2.out_imm !== {64'h1000, 64'h0}) begin errors++; $display("FAIL lanes masked out_imm=%h expected %h", bus2.out_imm, {64'h1000, 64'h0}); end
        checks++; if (bus2.out_lane_en !== 2'b10) begin errors++; $display("FAIL lanes out_lane_en=%b expected 10", bus2.out_lane_en); end
        checks++; if (bus2.out_err !== 2'b00) begin errors++; $display("FAIL lanes out_err=%b expected 00", bus2.out_err); end
        $display("lanes en=10 imm=%h", bus2.out_imm);
        bus2.in_lane_en = 2'b11;
        tick();
        bus2.in_valid = 1'b0;
        checks++; if (bus2.out_imm !== {64'h1000, 64'hFFFFFFFFFFFFFFFF}) begin errors++; $display("FAIL lanes both out_imm=%h", bus2.out_imm); end
        checks++; if (bus2.out_lane_en !== 2'b11) begin errors++; $display("FAIL lanes both out_lane_en=%b expected 11", bus2.out_lane_en); end
        $display("lanes en=11 imm=%h", bus2.out_imm);
        tick();
    endtask

    task automatic test_async_reset();
        bus64.out_ready = 1'b0;
        drive1(32'h00100093, Gen_1);
        tick();
        drive1(32'h00200093, Gen_1);
        tick();
        idle1();
        checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL areset full in_ready=%b expected 0", bus64.in_ready); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL areset out_valid=%b expected 0", bus64.out_valid); end
        checks++; if (bus64.out_imm !== 64'h0) begin errors++; $display("FAIL areset out_imm=%h expected 0", bus64.out_imm); end
        checks++; if (bus64.out_lane_en !== 1'b0) begin errors++; $display("FAIL areset out_lane_en=%b expected 0", bus64.out_lane_en); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL areset release in_ready=%b expected 1", bus64.in_ready); end
        bus64.out_ready = 1'b1;
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL areset stale out_valid=%b expected 0", bus64.out_valid); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_shamt();
        test_back_to_back();
        test_flush();
        test_lanes();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
